// File: rtl/vga_scan_timing.sv
`default_nettype none
// ============================================================================
//  Module   : vga_scan_timing
//  Purpose  : 640x480@60 Hz VGA raster timing generator. Produces the pixel
//             and line counters, active-low horizontal/vertical sync, a
//             display-active flag and a one-cycle start-of-frame strobe.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    vga_clk     in   1   pixel clock (25 MHz nominal), only clock
//    reset       in   1   synchronous, active-high reset
//    DrawX       out  10  horizontal pixel index, 0..H_TOTAL-1
//    DrawY       out  10  line index, 0..V_TOTAL-1
//    hs          out  1   horizontal sync, active low
//    vs          out  1   vertical sync, active low
//    blank       out  1   1 = visible region, 0 = blanking
//    frame_start out  1   one-cycle pulse at pixel (0,0)
// ----------------------------------------------------------------------------
//  Build option
//    VGA_SYNC_DELAY_EN  when defined, hs/vs/blank pass through one extra
//                       register so they align with a renderer whose colour
//                       is registered one cycle after DrawX/DrawY.
//                       DrawX, DrawY and frame_start are not delayed.
// ----------------------------------------------------------------------------
//  Counters are 10 bits wide; parameter sets whose totals exceed 1024 are
//  not supported.
// ============================================================================
module vga_scan_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start
);

    localparam logic [9:0] c_h_last     = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_v_last     = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] c_h_vis      = 10'(H_VISIBLE);
    localparam logic [9:0] c_v_vis      = 10'(V_VISIBLE);
    localparam logic [9:0] c_hs_start   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] c_hs_end     = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] c_vs_start   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] c_vs_end     = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_hs;
    logic       r_vs;
    logic       r_blank;
    logic       r_frame_start;

    logic [9:0] w_x_nxt;
    logic [9:0] w_y_nxt;
    logic       w_hs_nxt;
    logic       w_vs_nxt;
    logic       w_blank_nxt;
    logic       w_frame_start_nxt;

    // Next-state counters; the flags are decoded from these next values so
    // that once registered they describe the same pixel as DrawX/DrawY.
    always_comb begin
        w_x_nxt = r_x + 10'd1;
        w_y_nxt = r_y;
        if (r_x == c_h_last) begin
            w_x_nxt = '0;
            w_y_nxt = (r_y == c_v_last) ? 10'd0 : (r_y + 10'd1);
        end

        w_hs_nxt          = ~((w_x_nxt >= c_hs_start) && (w_x_nxt < c_hs_end));
        w_vs_nxt          = ~((w_y_nxt >= c_vs_start) && (w_y_nxt < c_vs_end));
        w_blank_nxt       = (w_x_nxt < c_h_vis) && (w_y_nxt < c_v_vis);
        w_frame_start_nxt = (w_x_nxt == 10'd0) && (w_y_nxt == 10'd0);
    end

    // Reset parks the counters on the last pixel of the frame so the first
    // edge after release lands on (0,0).
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_x           <= c_h_last;
            r_y           <= c_v_last;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_hs          <= w_hs_nxt;
            r_vs          <= w_vs_nxt;
            r_blank       <= w_blank_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    assign DrawX       = r_x;
    assign DrawY       = r_y;
    assign frame_start = r_frame_start;

`ifdef VGA_SYNC_DELAY_EN
    logic r_hs_d;
    logic r_vs_d;
    logic r_blank_d;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_hs_d    <= 1'b1;
            r_vs_d    <= 1'b1;
            r_blank_d <= 1'b0;
        end else begin
            r_hs_d    <= r_hs;
            r_vs_d    <= r_vs;
            r_blank_d <= r_blank;
        end
    end

    assign hs    = r_hs_d;
    assign vs    = r_vs_d;
    assign blank = r_blank_d;
`else
    assign hs    = r_hs;
    assign vs    = r_vs;
    assign blank = r_blank;
`endif

endmodule
`default_nettype wire
